// File: rtl/bus_demux_reg.sv
//------------------------------------------------------------------------------
// bus_demux_reg : ready/valid demultiplexer with one registered slot per channel.
// Optional broadcast port enabled by the BUS_DEMUX_BCAST_EN macro.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module bus_demux_reg #(
  parameter int WIDTH    = 9,
  parameter int CHANNELS = 2,
  localparam int SELW    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      nRst,
  input  logic [WIDTH-1:0]          inData,
  input  logic                      inValid,
  output logic                      inReady,
  input  logic [SELW-1:0]           sel,
`ifdef BUS_DEMUX_BCAST_EN
  input  logic                      bcast,
`endif
  output logic [CHANNELS*WIDTH-1:0] outData,
  output logic [CHANNELS-1:0]       outValid,
  input  logic [CHANNELS-1:0]       outReady,
  output logic                      errSel
);

  logic [CHANNELS-1:0] w_free;
  logic [CHANNELS-1:0] w_load;
  logic                w_bcast;
  logic                w_in_range;
  logic                w_free_sel;
  logic                w_xfer;

`ifdef BUS_DEMUX_BCAST_EN
  assign w_bcast = bcast;
`else
  assign w_bcast = 1'b0;
`endif

  assign w_free = ~outValid | outReady;

  always_comb begin
    w_free_sel = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel == SELW'(i)) w_free_sel = w_free[i];
    end
  end

  // Out-of-range selects are always accepted so the word can be discarded.
  assign inReady = w_bcast ? (&w_free) : (w_in_range ? w_free_sel : 1'b1);
  assign w_xfer  = inValid & inReady;

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_slot
      logic             r_valid;
      logic [WIDTH-1:0] r_data;

      assign w_load[i] = w_xfer & (w_bcast | (w_in_range & (sel == SELW'(i))));

      always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
          r_valid <= 1'b0;
          r_data  <= '0;
        end else if (w_load[i]) begin
          r_valid <= 1'b1;
          r_data  <= inData;
        end else if (outReady[i]) begin
          r_valid <= 1'b0;
        end
      end

      assign outValid[i]                = r_valid;
      assign outData[i*WIDTH +: WIDTH]  = r_data;
    end

    if ((CHANNELS & (CHANNELS - 1)) == 0) begin : g_pow2
      assign w_in_range = 1'b1;
      assign errSel     = 1'b0;
    end else begin : g_npow2
      logic r_err;

      assign w_in_range = ({1'b0, sel} < (SELW+1)'(CHANNELS));

      always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) r_err <= 1'b0;
        else       r_err <= inValid & ~w_bcast & ~w_in_range;
      end

      assign errSel = r_err;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_bus_demux_reg.sv
//------------------------------------------------------------------------------
// tb_bus_demux_reg : directed vector table plus randomized run against a queue model.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_bus_demux_reg;

  localparam int W  = 9;
  localparam int CH = 3;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            nRst;
  logic [W-1:0]    inData;
  logic            inValid;
  logic            inReady;
  logic [SW-1:0]   sel;
  logic            bcast;
  logic [CH*W-1:0] outData;
  logic [CH-1:0]   outValid;
  logic [CH-1:0]   outReady;
  logic            errSel;

  logic [4*W-1:0]  outData4;
  logic [3:0]      outValid4;
  logic            inReady4;
  logic            errSel4;

  bus_demux_reg #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk      (clk),
    .nRst     (nRst),
    .inData   (inData),
    .inValid  (inValid),
    .inReady  (inReady),
    .sel      (sel),
`ifdef BUS_DEMUX_BCAST_EN
    .bcast    (bcast),
`endif
    .outData  (outData),
    .outValid (outValid),
    .outReady (outReady),
    .errSel   (errSel)
  );

  // Power-of-two instance: its errSel must never pulse.
  bus_demux_reg #(.WIDTH(W), .CHANNELS(4)) dut4 (
    .clk      (clk),
    .nRst     (nRst),
    .inData   (inData),
    .inValid  (inValid),
    .inReady  (inReady4),
    .sel      (sel),
`ifdef BUS_DEMUX_BCAST_EN
    .bcast    (bcast),
`endif
    .outData  (outData4),
    .outValid (outValid4),
    .outReady (4'hF),
    .errSel   (errSel4)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each channel is a queue of capacity one; hold keeps the last word shown.
  logic [W-1:0] mq [CH][$];
  logic [W-1:0] hold [CH];
  logic         m_err;

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      mq[i].delete();
      hold[i] = '0;
    end
    m_err = 1'b0;
  endtask

  task automatic run_cycle(input logic v, input logic [SW-1:0] s, input logic [W-1:0] d,
                           input logic [CH-1:0] r, input logic b_in);
    logic [CH-1:0]   ev;
    logic [CH-1:0]   fr;
    logic [CH*W-1:0] ed;
    logic            er;
    logic            b;
`ifdef BUS_DEMUX_BCAST_EN
    b = b_in;
`else
    b = 1'b0;
`endif
    inValid = v; sel = s; inData = d; outReady = r; bcast = b;
    #1;
    for (int i = 0; i < CH; i++) begin
      ev[i]         = (mq[i].size() != 0);
      ed[i*W +: W]  = hold[i];
      fr[i]         = !ev[i] || r[i];
    end
    if (b)                er = &fr;
    else if (int'(s) < CH) er = fr[int'(s)];
    else                  er = 1'b1;
    chk("rand_outValid", 64'(outValid), 64'(ev));
    chk("rand_outData",  64'(outData),  64'(ed));
    chk("rand_inReady",  64'(inReady),  64'(er));
    chk("rand_errSel",   64'(errSel),   64'(m_err));
    chk("pow2_errSel",   64'(errSel4),  64'd0);
    @(posedge clk);
    for (int i = 0; i < CH; i++) begin
      if (ev[i] && r[i]) void'(mq[i].pop_front());
      if (v && er && (b || int'(s) == i)) begin
        mq[i].push_back(d);
        hold[i] = d;
      end
    end
    m_err = v && !b && (int'(s) >= CH);
    @(negedge clk);
  endtask

  typedef struct {
    logic            v;
    logic [SW-1:0]   s;
    logic [W-1:0]    d;
    logic [CH-1:0]   r;
    logic            exp_rdy;
    logic [CH-1:0]   exp_ov;
    logic [CH*W-1:0] exp_od;
    logic            exp_err;
  } vec_t;

  vec_t tab [12];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0] = '{1'b1, 2'd1, 9'h155, 3'b000, 1'b1, 3'b010, {9'h000, 9'h155, 9'h000}, 1'b0};
    for (int k = 1; k <= 5; k++)
      tab[k] = '{1'b1, 2'd1, 9'h0AA, 3'b000, 1'b0, 3'b010, {9'h000, 9'h155, 9'h000}, 1'b0};
    tab[6]  = '{1'b1, 2'd0, 9'h0AA, 3'b000, 1'b1, 3'b011, {9'h000, 9'h155, 9'h0AA}, 1'b0};
    tab[7]  = '{1'b1, 2'd0, 9'h033, 3'b001, 1'b1, 3'b011, {9'h000, 9'h155, 9'h033}, 1'b0};
    tab[8]  = '{1'b1, 2'd3, 9'h1FF, 3'b000, 1'b1, 3'b011, {9'h000, 9'h155, 9'h033}, 1'b1};
    tab[9]  = '{1'b0, 2'd0, 9'h000, 3'b000, 1'b0, 3'b011, {9'h000, 9'h155, 9'h033}, 1'b0};
    tab[10] = '{1'b0, 2'd2, 9'h000, 3'b011, 1'b1, 3'b000, {9'h000, 9'h155, 9'h033}, 1'b0};
    tab[11] = '{1'b1, 2'd2, 9'h1C3, 3'b000, 1'b1, 3'b100, {9'h1C3, 9'h155, 9'h033}, 1'b0};

    nRst = 1'b0; inValid = 1'b0; sel = '0; inData = '0; outReady = '0; bcast = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outValid", 64'(outValid), 64'd0);
    chk("reset_outData",  64'(outData),  64'd0);
    chk("reset_errSel",   64'(errSel),   64'd0);
    chk("reset_inReady",  64'(inReady),  64'd1);
    nRst = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 12; k++) begin
      inValid = tab[k].v; sel = tab[k].s; inData = tab[k].d; outReady = tab[k].r;
      #1;
      chk($sformatf("vec%0d_inReady", k), 64'(inReady), 64'(tab[k].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_outValid", k), 64'(outValid), 64'(tab[k].exp_ov));
      chk($sformatf("vec%0d_outData", k),  64'(outData),  64'(tab[k].exp_od));
      chk($sformatf("vec%0d_errSel", k),   64'(errSel),   64'(tab[k].exp_err));
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a cycle with slots occupied.
    inValid = 1'b1; sel = 2'd0; inData = 9'h0AA; outReady = 3'b000;
    @(posedge clk);
    #2;
    nRst = 1'b0;
    #1;
    chk("async_outValid", 64'(outValid), 64'd0);
    chk("async_outData",  64'(outData),  64'd0);
    chk("async_errSel",   64'(errSel),   64'd0);
    chk("async_inReady",  64'(inReady),  64'd1);
    @(negedge clk);
    inValid = 1'b0;
    nRst = 1'b1;
    model_reset();

    run_cycle(1'b1, 2'd1, 9'h155, 3'b000, 1'b0);
    run_cycle(1'b0, 2'd0, 9'h000, 3'b111, 1'b0);

`ifdef BUS_DEMUX_BCAST_EN
    run_cycle(1'b1, 2'd3, 9'h1FF, 3'b000, 1'b1);
    chk("bcast_outValid", 64'(outValid), 64'h7);
    chk("bcast_outData",  64'(outData),  64'({9'h1FF, 9'h1FF, 9'h1FF}));
    run_cycle(1'b1, 2'd0, 9'h0AA, 3'b110, 1'b1);
    run_cycle(1'b0, 2'd0, 9'h000, 3'b111, 1'b0);
`endif

    for (int n = 0; n < 400; n++) begin
      run_cycle(($urandom_range(0, 3) != 0), SW'($urandom_range(0, 3)),
                W'($urandom), CH'($urandom), ($urandom_range(0, 5) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bus_demux_reg.md
BUS_DEMUX_REG -- requirements
Module: bus_demux_reg

Interface
REQ-001 Parameter: WIDTH, default 9, data width in bits, legal range 1..32.
REQ-002 Parameter: CHANNELS, default 2, number of output channels, legal range 2..16.
REQ-003 Derived localparam: SELW = ceil(log2(CHANNELS)), select width.
REQ-004 Port: clk  input  1  rising-edge clock for all state.
REQ-005 Port: nRst  input  1  reset, asynchronous assert, active-low.
REQ-006 Port: inData  input  WIDTH  input word.
REQ-007 Port: inValid  input  1  input word present.
REQ-008 Port: inReady  output  1  block accepts input this cycle.
REQ-009 Port: sel  input  SELW  destination channel, sampled with inData.
REQ-010 Port: bcast  input  1  broadcast request; exists only when BUS_DEMUX_BCAST_EN is defined.
REQ-011 Port: outData  output  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-012 Port: outValid  output  CHANNELS  per-channel data valid.
REQ-013 Port: outReady  input  CHANNELS  per-channel consumer ready.
REQ-014 Port: errSel  output  1  one-cycle pulse on out-of-range select.

Function
REQ-015 Each channel SHALL hold exactly one registered slot (data plus valid bit).
REQ-016 Slot i is free when !outValid[i] or outReady[i].
REQ-017 With a non-broadcast request and sel < CHANNELS, inReady SHALL equal free[sel], combinationally.
REQ-018 A transfer occurs when inValid and inReady are both high at a rising edge.
REQ-019 On a transfer, slot sel SHALL load inData, and outValid[sel] SHALL be 1 from the next cycle. Input-to-output latency is 1 cycle.
REQ-020 An output handshake (outValid[i] and outReady[i]) with no load into slot i SHALL clear outValid[i] at the edge.
REQ-021 A simultaneous drain and load of the same slot SHALL present the new word, and outValid SHALL stay 1 with no bubble.
REQ-022 While outValid[i]=1 and outReady[i]=0, outData slice i SHALL remain stable.
REQ-023 Non-selected channels SHALL hold their data and valid bits; data is never zeroed by deselection.
REQ-024 If sel >= CHANNELS and inValid=1, then inReady=1, the word is discarded, no slot changes, and errSel=1 for exactly the following cycle.
REQ-025 When CHANNELS is a power of two, errSel SHALL be constant 0.
REQ-026 Data SHALL never be duplicated, reordered within a channel, or lost, except by REQ-024.
REQ-027 inValid=0 SHALL leave all slots unchanged apart from drains.

Reset
REQ-028 While nRst=0: all outValid=0, all outData=0, errSel=0, and inReady reflects an empty state.
REQ-029 Reset asserted mid-transfer SHALL discard all held words. The first cycle after deassertion SHALL behave as if empty.

Configuration
REQ-030 Macro BUS_DEMUX_BCAST_EN defined: the bcast port exists.
- With bcast=1 and inValid=1: inReady = AND of free[i] over all channels; sel is ignored; no errSel.
- A broadcast transfer loads inData into every slot in the same edge.
REQ-031 Macro BUS_DEMUX_BCAST_EN undefined: no bcast port; behaviour is identical to bcast=0; no broadcast logic is synthesised.

Verification
REQ-032 Reset then sel=1, inData=0x155, inValid=1, outReady=00 -> next cycle outValid=10, outData[17:9]=0x155, outData[8:0]=0.
REQ-033 Channel 1 full, outReady[1]=0, sel=1, inValid=1 -> inReady=0; outData slice 1 holds 0x155 for 5 cycles.
REQ-034 Channel 0 full, outReady[0]=1, sel=0, inData=0x0AA, inValid=1 -> inReady=1; next cycle outValid[0]=1 and data 0x0AA, with no bubble.
REQ-035 CHANNELS=3, sel=3, inValid=1 -> inReady=1; errSel=1 for one cycle; outValid unchanged.
REQ-036 BUS_DEMUX_BCAST_EN, CHANNELS=4, all empty, bcast=1, inData=0x1FF -> next cycle outValid=1111 and every slice=0x1FF. Same stimulus with one channel full and not ready -> inReady=0.
REQ-037 Load channel 0, assert nRst=0 mid-cycle -> outValid=00 immediately (asynchronous), outData=0.
